// File: rtl/exc_commit_ctrl_if.sv
// M-stage exception record in, CP0 update / flush / redirect strobes out.
interface exc_commit_ctrl_if;
  logic [4:0]  except_typeM;
  logic [31:0] pc_exceptionM;
  logic [31:0] pcM;
  logic [31:0] badvaddrM;
  logic        is_in_delayslotM;
  logic        mem_busy;

  logic        stall_req;
  logic        flush_all;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        cp0_exc_we;
  logic        cp0_eret;
  logic [4:0]  cp0_exc_code;
  logic [31:0] cp0_epc;
  logic        cp0_bd;
  logic [31:0] cp0_badvaddr;
  logic [31:0] exc_count;
  logic        drain_timeout;

  // Exception unit / pipeline side
  modport master (
    output except_typeM, pc_exceptionM, pcM, badvaddrM, is_in_delayslotM, mem_busy,
    input  stall_req, flush_all, redirect_valid, redirect_pc, cp0_exc_we, cp0_eret,
           cp0_exc_code, cp0_epc, cp0_bd, cp0_badvaddr, exc_count, drain_timeout
  );

  // Commit controller side
  modport slave (
    input  except_typeM, pc_exceptionM, pcM, badvaddrM, is_in_delayslotM, mem_busy,
    output stall_req, flush_all, redirect_valid, redirect_pc, cp0_exc_we, cp0_eret,
           cp0_exc_code, cp0_epc, cp0_bd, cp0_badvaddr, exc_count, drain_timeout
  );
endinterface

// File: rtl/exc_commit_ctrl.sv
// Precise exception / ERET commit sequencer: latch record, drain the bus, then
// issue CP0 update, flush and redirect together in one COMMIT cycle.
module exc_commit_ctrl #(
  parameter int unsigned DRAIN_TIMEOUT = 255
) (
  input logic              clk,
  input logic              resetn,
  exc_commit_ctrl_if.slave bus
);

  localparam logic [4:0] EXC_CODE_NOEXC = 5'h1f;
  localparam logic [4:0] EXC_CODE_ERET  = 5'h0e;
  localparam logic [7:0] TimeoutCnt     = 8'(DRAIN_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StDrain, StCommit} state_e;

  state_e      r_state;
  logic [4:0]  r_exc_code;
  logic [31:0] r_target;
  logic [31:0] r_pc;
  logic [31:0] r_badvaddr;
  logic        r_bd;
  logic [7:0]  r_drain_cnt;
  logic [31:0] r_exc_count;
  logic        r_drain_timeout;

  logic w_req;
  logic w_commit;
  logic w_is_eret;

  // Gating with resetn keeps every output low while reset is held.
  assign w_req     = resetn && (bus.except_typeM != EXC_CODE_NOEXC);
  assign w_commit  = (r_state == StCommit);
  assign w_is_eret = (r_exc_code == EXC_CODE_ERET);

  // Sequencer state, latched exception record and counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= StIdle;
      r_exc_code      <= '0;
      r_target        <= '0;
      r_pc            <= '0;
      r_badvaddr      <= '0;
      r_bd            <= 1'b0;
      r_drain_cnt     <= '0;
      r_exc_count     <= '0;
      r_drain_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
            r_exc_code  <= bus.except_typeM;
            r_target    <= bus.pc_exceptionM;
            r_pc        <= bus.pcM;
            r_badvaddr  <= bus.badvaddrM;
            r_bd        <= bus.is_in_delayslotM;
            r_drain_cnt <= '0;
            r_state     <= StDrain;
          end
        end
        StDrain: begin
          if (!bus.mem_busy) begin
            r_state <= StCommit;
          end else if (r_drain_cnt == TimeoutCnt) begin
            // Bus never drained: commit anyway and leave a sticky marker.
            r_drain_timeout <= 1'b1;
            r_state         <= StCommit;
          end else begin
            r_drain_cnt <= r_drain_cnt + 8'd1;
          end
        end
        StCommit: begin
          if (!w_is_eret) r_exc_count <= r_exc_count + 32'd1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Outputs decode from state and latched record only (plus req in IDLE for stall).
  always_comb begin
    bus.stall_req      = 1'b0;
    bus.flush_all      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.cp0_exc_we     = 1'b0;
    bus.cp0_eret       = 1'b0;
    bus.cp0_exc_code   = '0;
    bus.cp0_epc        = '0;
    bus.cp0_bd         = 1'b0;
    bus.cp0_badvaddr   = '0;
    unique case (r_state)
      StIdle:  bus.stall_req = w_req;
      StDrain: bus.stall_req = 1'b1;
      StCommit: begin
        bus.stall_req      = 1'b1;
        bus.flush_all      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = r_target;
        if (w_is_eret) begin
          bus.cp0_eret = 1'b1;
        end else begin
          bus.cp0_exc_we   = 1'b1;
          bus.cp0_exc_code = r_exc_code;
          bus.cp0_bd       = r_bd;
          bus.cp0_epc      = r_bd ? (r_pc - 32'd4) : r_pc;
          bus.cp0_badvaddr = r_badvaddr;
        end
      end
      default: bus.stall_req = 1'b0;
    endcase
  end

  assign bus.exc_count     = r_exc_count;
  assign bus.drain_timeout = r_drain_timeout;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
module tb_exc_commit_ctrl;

  localparam logic [4:0] NOEXC = 5'h1f;
  localparam logic [4:0] ERET  = 5'h0e;
  localparam logic [4:0] SYS   = 5'h08;
  localparam logic [4:0] ADEL  = 5'h04;
  localparam logic [4:0] ADES  = 5'h05;
  localparam logic [4:0] OV    = 5'h0c;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  exc_commit_ctrl_if bus ();
  exc_commit_ctrl_if bus2 ();

  exc_commit_ctrl u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  exc_commit_ctrl #(.DRAIN_TIMEOUT(3)) u_dut_to (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req1(input logic [4:0] code, input logic [31:0] tgt, input logic [31:0] pc,
                      input logic [31:0] bad, input logic bd);
    bus.except_typeM     = code;
    bus.pc_exceptionM    = tgt;
    bus.pcM              = pc;
    bus.badvaddrM        = bad;
    bus.is_in_delayslotM = bd;
  endtask

  task automatic clr1();
    req1(NOEXC, 32'hdead_0000, 32'hdead_1111, 32'hdead_2222, 1'b1);
  endtask

  initial begin
    resetn = 1'b0;
    clr1();
    bus.mem_busy          = 1'b0;
    bus2.except_typeM     = NOEXC;
    bus2.pc_exceptionM    = '0;
    bus2.pcM              = '0;
    bus2.badvaddrM        = '0;
    bus2.is_in_delayslotM = 1'b0;
    bus2.mem_busy         = 1'b0;
    #2;
    chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("rst_redir", {31'd0, bus.redirect_valid}, 32'd0);
    chk("rst_count", bus.exc_count, 32'd0);
    chk("rst_to", {31'd0, bus.drain_timeout}, 32'd0);
    cyc();
    cyc();
    resetn = 1'b1;
    cyc();

    // 1: SYS, no BD, bus idle
    req1(SYS, 32'hbfc0_0380, 32'hbfc0_0100, 32'h0, 1'b0);
    #1 chk("t1_c0_stall", {31'd0, bus.stall_req}, 32'd1);
    chk("t1_c0_flush", {31'd0, bus.flush_all}, 32'd0);
    cyc(); clr1();
    #1 chk("t1_c1_stall", {31'd0, bus.stall_req}, 32'd1);
    chk("t1_c1_redir", {31'd0, bus.redirect_valid}, 32'd0);
    cyc();
    #1 chk("t1_c2_stall", {31'd0, bus.stall_req}, 32'd1);
    chk("t1_c2_flush", {31'd0, bus.flush_all}, 32'd1);
    chk("t1_c2_redir", {31'd0, bus.redirect_valid}, 32'd1);
    chk("t1_c2_rpc", bus.redirect_pc, 32'hbfc0_0380);
    chk("t1_c2_we", {31'd0, bus.cp0_exc_we}, 32'd1);
    chk("t1_c2_eret", {31'd0, bus.cp0_eret}, 32'd0);
    chk("t1_c2_code", {27'd0, bus.cp0_exc_code}, 32'h08);
    chk("t1_c2_epc", bus.cp0_epc, 32'hbfc0_0100);
    chk("t1_c2_bd", {31'd0, bus.cp0_bd}, 32'd0);
    cyc();
    #1 chk("t1_c3_count", bus.exc_count, 32'd1);
    chk("t1_c3_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("t1_c3_redir", {31'd0, bus.redirect_valid}, 32'd0);
    chk("t1_c3_epc", bus.cp0_epc, 32'd0);

    // 2: ADEL in a delay slot, accepted in the cycle right after COMMIT
    req1(ADEL, 32'hbfc0_0380, 32'h8000_0010, 32'h8000_0003, 1'b1);
    cyc(); clr1();
    cyc();
    #1 chk("t2_epc", bus.cp0_epc, 32'h8000_000c);
    chk("t2_bd", {31'd0, bus.cp0_bd}, 32'd1);
    chk("t2_bad", bus.cp0_badvaddr, 32'h8000_0003);
    chk("t2_code", {27'd0, bus.cp0_exc_code}, 32'h04);
    cyc();
    #1 chk("t2_count", bus.exc_count, 32'd2);

    // 3: ERET
    req1(ERET, 32'h8000_2000, 32'h8000_0040, 32'h0, 1'b0);
    cyc(); clr1();
    cyc();
    #1 chk("t3_eret", {31'd0, bus.cp0_eret}, 32'd1);
    chk("t3_we", {31'd0, bus.cp0_exc_we}, 32'd0);
    chk("t3_rpc", bus.redirect_pc, 32'h8000_2000);
    chk("t3_flush", {31'd0, bus.flush_all}, 32'd1);
    cyc();
    #1 chk("t3_count", bus.exc_count, 32'd2);
    chk("t3_eret_off", {31'd0, bus.cp0_eret}, 32'd0);

    // 4: five busy DRAIN cycles; type changes mid-drain must be ignored
    req1(ADES, 32'hbfc0_0380, 32'h8000_1000, 32'h8000_1002, 1'b0);
    bus.mem_busy = 1'b1;
    cyc(); clr1();                               // cycle 1
    cyc(); req1(OV, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b1); // cycle 2
    cyc(); cyc(); cyc();                         // cycle 5
    #1 chk("t4_c5_redir", {31'd0, bus.redirect_valid}, 32'd0);
    cyc(); bus.mem_busy = 1'b0; clr1();          // cycle 6
    #1 chk("t4_c6_redir", {31'd0, bus.redirect_valid}, 32'd0);
    chk("t4_c6_stall", {31'd0, bus.stall_req}, 32'd1);
    cyc();                                       // cycle 7
    #1 chk("t4_c7_redir", {31'd0, bus.redirect_valid}, 32'd1);
    chk("t4_c7_code", {27'd0, bus.cp0_exc_code}, 32'h05);
    chk("t4_c7_epc", bus.cp0_epc, 32'h8000_1000);
    chk("t4_c7_bad", bus.cp0_badvaddr, 32'h8000_1002);
    cyc();
    #1 chk("t4_count", bus.exc_count, 32'd3);
    chk("t4_no_to", {31'd0, bus.drain_timeout}, 32'd0);

    // 5: DRAIN_TIMEOUT = 3, bus stuck busy
    bus2.except_typeM  = SYS;
    bus2.pc_exceptionM = 32'h0000_0180;
    bus2.pcM           = 32'h0000_0100;
    bus2.mem_busy      = 1'b1;
    cyc(); bus2.except_typeM = NOEXC;            // cycle 1
    cyc(); cyc(); cyc();                         // cycle 4
    #1 chk("t5_c4_redir", {31'd0, bus2.redirect_valid}, 32'd0);
    chk("t5_c4_to", {31'd0, bus2.drain_timeout}, 32'd0);
    cyc();                                       // cycle 5
    #1 chk("t5_c5_redir", {31'd0, bus2.redirect_valid}, 32'd1);
    chk("t5_c5_we", {31'd0, bus2.cp0_exc_we}, 32'd1);
    chk("t5_c5_to", {31'd0, bus2.drain_timeout}, 32'd1);
    cyc(); bus2.mem_busy = 1'b0;
    cyc();
    #1 chk("t5_sticky", {31'd0, bus2.drain_timeout}, 32'd1);
    chk("t5_count", bus2.exc_count, 32'd1);

    // 6: reset pulse during DRAIN
    req1(OV, 32'hbfc0_0380, 32'h8000_3000, 32'h0, 1'b0);
    bus.mem_busy = 1'b1;
    cyc(); clr1();                               // DRAIN
    #1 resetn = 1'b0;
    #1 chk("t6_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("t6_count", bus.exc_count, 32'd0);
    chk("t6_to2", {31'd0, bus2.drain_timeout}, 32'd0);
    bus.mem_busy = 1'b0;
    cyc();
    chk("t6_redir", {31'd0, bus.redirect_valid}, 32'd0);
    chk("t6_we", {31'd0, bus.cp0_exc_we}, 32'd0);
    resetn = 1'b1;
    cyc();
    #1 chk("t6_idle_redir", {31'd0, bus.redirect_valid}, 32'd0);
    chk("t6_idle_flush", {31'd0, bus.flush_all}, 32'd0);
    req1(SYS, 32'hbfc0_0380, 32'h8000_4000, 32'h0, 1'b0);
    #1 chk("t6_new_stall", {31'd0, bus.stall_req}, 32'd1);
    cyc(); clr1();
    cyc();
    #1 chk("t6_new_redir", {31'd0, bus.redirect_valid}, 32'd1);
    chk("t6_new_epc", bus.cp0_epc, 32'h8000_4000);
    cyc();
    #1 chk("t6_new_count", bus.exc_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
